word_to_byte: RTL and testbench

WORD_TO_BYTE -- requirements
Module: word_to_byte

---
 rtl/byte_stream_pkg.sv | 11 +
 rtl/word_fifo.sv | 54 +++++
 rtl/word_to_byte.sv | 114 +++++++++++
 tb/tb_word_to_byte.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/byte_stream_pkg.sv
// Shared definitions for the word-to-byte serializer: byte width and FSM state encoding.
package byte_stream_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/word_fifo.sv
// Small power-of-two word buffer with registered pointers and an occupancy counter.
module word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  // Guarded so the counter can neither overflow nor underflow.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/word_to_byte.sv
// Serializes buffered words into a byte stream with valid/accept handshakes on both sides.
module word_to_byte
  import byte_stream_pkg::*;
#(
  parameter int unsigned BPW        = 4,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_valid,
  input  logic [BPW*8-1:0]              word_in,
  output logic                          w_ready,
  output logic                          b_rdy,
  input  logic                          b_akn,
  output logic [7:0]                    byte_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          busy
);

  localparam int unsigned WordW = BPW * ByteW;
  localparam int unsigned IdxW  = (BPW > 2) ? $clog2(BPW) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d, sel;
  logic [WordW-1:0]  shift_q, shift_d, head;
  logic [ByteW-1:0]  byte_sel;
  logic [CntW-1:0]   cnt;
  logic              fifo_full, fifo_empty;
  logic              push, pop, last;

  // Held low during reset so no word can slip in while state is being cleared.
  assign w_ready = !fifo_full && !rst;
  assign push    = w_valid && w_ready;

  word_fifo #(
    .WIDTH (WordW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (word_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign last = (idx_q == IdxW'(BPW - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (b_akn) begin
          if (last) begin
            idx_d = '0;
            // Reload straight from the buffer so consecutive words leave no gap.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
            end else begin
              shift_d = '0;
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel = MSB_FIRST ? (IdxW'(BPW - 1) - idx_q) : idx_q;
    byte_sel = '0;
    for (int unsigned i = 0; i < BPW; i++) begin
      if (sel == IdxW'(i)) byte_sel = shift_q[i*ByteW +: ByteW];
    end
  end

  assign b_rdy    = (state_q == SEND);
  assign byte_out = b_rdy ? byte_sel : '0;
  assign fifo_cnt = cnt;
  assign busy     = (cnt != '0) || b_rdy;

endmodule

// File: tb/tb_word_to_byte.sv
// Directed and randomized checks of word_to_byte in LSB-first and MSB-first builds.
module tb_word_to_byte;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid;
  logic [31:0] word_in;
  logic        b_akn;
  logic        w_ready, b_rdy, busy;
  logic [7:0]  byte_out;
  logic [1:0]  fifo_cnt;
  logic        w_ready_m, b_rdy_m, busy_m;
  logic [7:0]  byte_out_m;
  logic [1:0]  fifo_cnt_m;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ref_q[$];

  always #5 clk = ~clk;

  word_to_byte #(.BPW(4), .MSB_FIRST(1'b0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .word_in(word_in), .w_ready(w_ready),
    .b_rdy(b_rdy), .b_akn(b_akn), .byte_out(byte_out), .fifo_cnt(fifo_cnt), .busy(busy)
  );

  word_to_byte #(.BPW(4), .MSB_FIRST(1'b1), .FIFO_DEPTH(2)) dut_m (
    .clk(clk), .rst(rst), .w_valid(w_valid), .word_in(word_in), .w_ready(w_ready_m),
    .b_rdy(b_rdy_m), .b_akn(b_akn), .byte_out(byte_out_m), .fifo_cnt(fifo_cnt_m),
    .busy(busy_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the presented byte, advances one cycle, then drops w_valid so a word
  // offered in the checked cycle is pushed exactly once.
  task automatic exp_byte(input string tag, input logic [7:0] v);
    chk({tag, "_rdy"}, 32'(b_rdy), 32'd1);
    chk(tag, 32'(byte_out), 32'(v));
    tick();
    w_valid = 1'b0;
  endtask

  task automatic exp_word(input string tag, input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_byte(tag, w[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    w_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] w;
    bit w_fire, b_fire;
    rst = 1'b1; w_valid = 1'b0; word_in = '0; b_akn = 1'b0;
    tick(); tick();
    chk("rst_w_ready", 32'(w_ready), 0);
    chk("rst_b_rdy", 32'(b_rdy), 0);
    chk("rst_byte", 32'(byte_out), 0);
    chk("rst_cnt", 32'(fifo_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    chk("idle_w_ready", 32'(w_ready), 1);

    // Single word, LSB first, latency of two cycles.
    b_akn = 1'b1; w_valid = 1'b1; word_in = 32'hDDCCBBAA;
    tick();
    w_valid = 1'b0;
    chk("lat_b_rdy", 32'(b_rdy), 0);
    chk("lat_cnt", 32'(fifo_cnt), 1);
    chk("lat_busy", 32'(busy), 1);
    tick();
    exp_word("lsb", 32'hDDCCBBAA);
    chk("lsb_done_rdy", 32'(b_rdy), 0);
    chk("lsb_done_busy", 32'(busy), 0);
    chk("lsb_done_byte", 32'(byte_out), 0);

    // MSB-first build against the same word stream.
    w_valid = 1'b1; word_in = 32'h11223344;
    tick();
    w_valid = 1'b0;
    chk("msb_cnt", 32'(fifo_cnt_m), 1);
    tick();
    w = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      chk("msb_rdy", 32'(b_rdy_m), 1);
      chk("msb_byte", 32'(byte_out_m), 32'(w[8*i +: 8]));
      chk("msb_lsb_byte", 32'(byte_out), 32'(w[8*(3-i) +: 8]));
      tick();
    end
    chk("msb_done_rdy", 32'(b_rdy_m), 0);
    chk("msb_done_busy", 32'(busy_m), 0);
    chk("msb_w_ready", 32'(w_ready_m), 1);

    // Stall on BB while two more words fill the buffer.
    w_valid = 1'b1; word_in = 32'hDDCCBBAA;
    tick();
    w_valid = 1'b0;
    tick();
    exp_byte("stall_pre", 8'hAA);
    b_akn = 1'b0; w_valid = 1'b1; word_in = 32'h44332211;
    chk("stall_w_ready", 32'(w_ready), 1);
    for (int h = 0; h < 5; h++) begin
      chk("stall_rdy", 32'(b_rdy), 1);
      chk("stall_byte", 32'(byte_out), 32'hBB);
      if (h == 1) chk("stall_cnt1", 32'(fifo_cnt), 1);
      if (h == 2) begin
        chk("stall_cnt2", 32'(fifo_cnt), 2);
        chk("stall_full", 32'(w_ready), 0);
      end
      tick();
      if (h == 0) word_in = 32'h88776655;
      if (h == 1) w_valid = 1'b0;
    end
    b_akn = 1'b1;
    exp_byte("stall_post", 8'hBB);
    exp_byte("stall_post", 8'hCC);
    chk("stall_cnt_dd", 32'(fifo_cnt), 2);
    exp_byte("stall_post", 8'hDD);
    chk("stall_cnt_w2", 32'(fifo_cnt), 1);
    exp_word("stall_w2", 32'h44332211);
    exp_word("stall_w3", 32'h88776655);
    chk("stall_done", 32'(busy), 0);

    // Three back-to-back words: no bubble at word boundaries.
    w_valid = 1'b1; word_in = 32'h13121110;
    tick();
    word_in = 32'h23222120;
    chk("b2b_cnt", 32'(fifo_cnt), 1);
    tick();
    word_in = 32'h33323130;
    chk("b2b_w_ready", 32'(w_ready), 1);
    exp_word("b2b_1", 32'h13121110);
    exp_word("b2b_2", 32'h23222120);
    exp_word("b2b_3", 32'h33323130);
    chk("b2b_done", 32'(b_rdy), 0);

    // Reset mid-word with one word buffered.
    w_valid = 1'b1; word_in = 32'hA4A3A2A1;
    tick();
    word_in = 32'hB4B3B2B1;
    tick();
    w_valid = 1'b0;
    exp_byte("mid", 8'hA1);
    exp_byte("mid", 8'hA2);
    chk("mid_cnt", 32'(fifo_cnt), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_cnt", 32'(fifo_cnt), 0);
    chk("mid_rst_rdy", 32'(b_rdy), 0);
    chk("mid_rst_byte", 32'(byte_out), 0);
    chk("mid_rst_w_ready", 32'(w_ready), 0);
    rst = 1'b0;
    tick();
    chk("post_rst_rdy", 32'(b_rdy), 0);
    chk("post_rst_busy", 32'(busy), 0);
    w_valid = 1'b1; word_in = 32'h04030201;
    tick();
    w_valid = 1'b0;
    tick();
    exp_word("post_rst", 32'h04030201);
    chk("post_rst_end", 32'(b_rdy), 0);
    chk("post_rst_end_busy", 32'(busy), 0);

    // Random traffic against a byte-level reference queue.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      chk("rnd_cnt_bound", 32'(fifo_cnt <= 2'd2), 1);
      w_valid = 1'($urandom_range(0, 1));
      word_in = $urandom;
      b_akn   = 1'($urandom_range(0, 1));
      #1;
      w_fire = w_valid && w_ready;
      b_fire = b_rdy && b_akn;
      if (b_fire) begin
        if (ref_q.size() == 0) begin
          chk("rnd_spurious", 32'(byte_out), 32'hFFFF_FFFF);
        end else begin
          chk("rnd_byte", 32'(byte_out), 32'(ref_q[0]));
          void'(ref_q.pop_front());
        end
      end
      if (w_fire) for (int i = 0; i < 4; i++) ref_q.push_back(word_in[8*i +: 8]);
      tick();
    end
    w_valid = 1'b0;
    b_akn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (b_rdy && ref_q.size() != 0) begin
        chk("drain_byte", 32'(byte_out), 32'(ref_q[0]));
        void'(ref_q.pop_front());
      end
      tick();
    end
    chk("drain_left", 32'(ref_q.size()), 0);
    chk("drain_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
